// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_ctrl_pkg;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_lock_sync.sv
// Two-flop synchronizer for asynchronous status inputs; both stages clear on reset.
module lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] meta_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: holds PLL reset, waits for and qualifies lock, releases sys_reset.
// Optional lock-loss counter output enabled by defining PLL_LOSS_CNT_EN.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  restart_req,
  output logic                  pll_reset,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  fail,
`ifdef PLL_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] loss_cnt,
`endif
  output logic [STATE_W-1:0]    state_o
);

  localparam int CNT_W   = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc_s;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_reset_q, sys_reset_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  lock_sync #(.WIDTH(1)) u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= {CNT_W{1'b0}};
      retry_q     <= {RETRY_W{1'b0}};
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next state; restart_req overrides every other transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    retry_inc_s = retry_q + RETRY_W'(1);
    if (restart_req) begin
      state_d = S_PLL_RST;
      cnt_d   = {CNT_W{1'b0}};
      retry_d = {RETRY_W{1'b0}};
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = {CNT_W{1'b0}};
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc_s;
            cnt_d   = {CNT_W{1'b0}};
            if (retry_inc_s == RETRY_LIMIT) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_PLL_RST;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // A dropout restarts qualification but is not a timeout, so retry is kept.
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = {CNT_W{1'b0}};
            retry_d = {RETRY_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_PLL_RST;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_RUN;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = {CNT_W{1'b0}};
          retry_d = {RETRY_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they flip on the transition edge.
  always_comb begin
    pll_reset_d = 1'b1;
    sys_reset_d = 1'b1;
    ready_d     = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      S_PLL_RST: begin
        pll_reset_d = 1'b1;
        sys_reset_d = 1'b1;
      end
      S_WAIT_LOCK, S_STABLE: begin
        pll_reset_d = 1'b0;
        sys_reset_d = 1'b1;
      end
      S_RUN: begin
        pll_reset_d = 1'b0;
        sys_reset_d = 1'b0;
        ready_d     = 1'b1;
      end
      S_FAIL: begin
        pll_reset_d = 1'b1;
        sys_reset_d = 1'b1;
        fail_d      = 1'b1;
      end
      default: begin
        pll_reset_d = 1'b1;
        sys_reset_d = 1'b1;
      end
    endcase
  end

`ifdef PLL_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // Count only lock-loss exits from S_RUN; restart_req exits are excluded.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (!restart_req && (state_q == S_RUN) && !lock_s &&
        (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_cnt_q <= {LOSS_CNT_W{1'b0}};
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_cnt = loss_cnt_q;
`endif

  assign pll_reset = pll_reset_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: phase table, corner sequences, randomized lock traffic vs model.
module tb_pll_lock_ctrl;

  localparam int RST = 8;
  localparam int TMO = 32;
  localparam int STB = 16;
  localparam int MR  = 2;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_reset, sys_reset, ready, fail;
  logic [2:0] state_o;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  always #5 clkin = ~clkin;

  pll_lock_ctrl #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TMO),
    .STABLE_CYCLES (STB),
    .MAX_RETRY     (MR)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .restart_req (restart_req),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fail        (fail),
`ifdef PLL_LOSS_CNT_EN
    .loss_cnt    (loss_cnt),
`endif
    .state_o     (state_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase, cycles spent in phase, timeout tally, 2-deep lock history.
  int m_st = 0;
  int m_el = 0;
  int m_tries = 0;
  int m_loss = 0;
  bit m_h0 = 1'b0;
  bit m_h1 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rq, input bit lk);
    bit ls;
    if (r) begin
      m_st = 0; m_el = 0; m_tries = 0; m_loss = 0; m_h0 = 1'b0; m_h1 = 1'b0;
    end else begin
      ls = m_h1;
      m_h1 = m_h0;
      m_h0 = lk;
      if (rq) begin
        m_st = 0; m_el = 0; m_tries = 0;
      end else begin
        case (m_st)
          0: begin
            m_el++;
            if (m_el == RST) begin m_st = 1; m_el = 0; end
          end
          1: begin
            if (ls) begin
              m_st = 2; m_el = 0;
            end else begin
              m_el++;
              if (m_el == TMO) begin
                m_tries++;
                m_el = 0;
                m_st = (m_tries == MR) ? 4 : 0;
              end
            end
          end
          2: begin
            if (!ls) begin
              m_st = 1; m_el = 0;
            end else begin
              m_el++;
              if (m_el == STB) begin m_st = 3; m_el = 0; m_tries = 0; end
            end
          end
          3: begin
            if (!ls) begin
              m_st = 0; m_el = 0;
              if (m_loss < 255) m_loss++;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_compare();
    check("mdl_state", int'(state_o), m_st);
    check("mdl_pll_reset", int'(pll_reset), (m_st == 0 || m_st == 4) ? 1 : 0);
    check("mdl_sys_reset", int'(sys_reset), (m_st != 3) ? 1 : 0);
    check("mdl_ready", int'(ready), (m_st == 3) ? 1 : 0);
    check("mdl_fail", int'(fail), (m_st == 4) ? 1 : 0);
`ifdef PLL_LOSS_CNT_EN
    check("mdl_loss_cnt", int'(loss_cnt), m_loss);
`endif
  endtask

  task automatic tick(input bit r, input bit rq, input bit lk);
    @(negedge clkin);
    reset = r;
    restart_req = rq;
    pll_lock = lk;
    @(posedge clkin);
    model_step(r, rq, lk);
    #1;
    model_compare();
  endtask

  task automatic check_outs(input string name, input int st, input bit pr, input bit sr,
                            input bit rdy, input bit fl);
    check({name, "_state"}, int'(state_o), st);
    check({name, "_pll_reset"}, int'(pll_reset), int'(pr));
    check({name, "_sys_reset"}, int'(sys_reset), int'(sr));
    check({name, "_ready"}, int'(ready), int'(rdy));
    check({name, "_fail"}, int'(fail), int'(fl));
  endtask

  typedef struct {
    bit rst;
    bit rq;
    bit lk;
    int cycles;
    int st;
    bit pr;
    bit sr;
    bit rdy;
    bit fl;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int run_left;
    bit lk_r;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 7,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1,  2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 15, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1,  3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2,  3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 31, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8,  1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 31, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1,  4, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 5,  4, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Phase table: reset, nominal lock, loss in run, two timeouts into FAIL, restart.
    for (int v = 0; v < 18; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        tick(vecs[v].rst, vecs[v].rq && (c == 0), vecs[v].lk);
      end
      check_outs($sformatf("vec%0d", v), vecs[v].st, vecs[v].pr, vecs[v].sr,
                 vecs[v].rdy, vecs[v].fl);
    end

    // Lock chatter at stable count 10: qualification restarts from zero.
    repeat (9) tick(1'b0, 1'b0, 1'b1);
    check("chat_enter_stable", int'(state_o), 2);
    repeat (10) tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    check("chat_back_wait", int'(state_o), 1);
    repeat (18) tick(1'b0, 1'b0, 1'b1);
    check_outs("chat_requal", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check_outs("chat_run", 3, 1'b0, 1'b0, 1'b1, 1'b0);

    // restart_req in S_RUN, then mid-S_STABLE.
    tick(1'b0, 1'b1, 1'b1);
    check_outs("rq_run", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b1);
    check("rq_pre_stable", int'(state_o), 2);
    tick(1'b0, 1'b1, 1'b1);
    check_outs("rq_stable", 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in S_WAIT_LOCK at count 20.
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    check_outs("wait20", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("rst_mid_wait", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    check_outs("rst_resequence", 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized lock runs with occasional restart and reset, checked every cycle.
    run_left = 0;
    lk_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit rq;
      if (run_left == 0) begin
        lk_r = ($urandom_range(0, 2) != 0);
        run_left = int'($urandom_range(1, 70));
      end
      run_left--;
      rq = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 599) == 0);
      tick(r, rq, lk_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
